// File: rtl/regfile_2r1w.sv
// regfile_2r1w: DEPTH = 2**SEL_W words of WIDTH bits. One synchronous write
// port and two independent registered read ports (A, B), each with a
// one-cycle read-enable/valid handshake. Index ZERO_REG reads as zero and
// ignores writes when ZERO_EN=1 and ZERO_REG < DEPTH.
// Optional macro REGFILE_WRITE_BYPASS_EN: a same-edge write to the address
// being read is forwarded to the read result (write-first). When the macro is
// left undefined, reads are read-first and no forwarding mux is built.
module regfile_2r1w #(
  parameter int WIDTH    = 64,
  parameter int SEL_W    = 5,
  parameter int ZERO_REG = 31,
  parameter int ZERO_EN  = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [SEL_W-1:0] wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en_a,
  input  logic [SEL_W-1:0] rd_sel_a,
  output logic [WIDTH-1:0] rd_data_a,
  output logic             rd_valid_a,
  input  logic             rd_en_b,
  input  logic [SEL_W-1:0] rd_sel_b,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             rd_valid_b,
  output logic             wr_ignored
);
  localparam int DEPTH = 2**SEL_W;
  // Zero register is active only if enabled and its index actually exists.
  localparam bit ZACTIVE = (ZERO_EN != 0) && (ZERO_REG >= 0) && (ZERO_REG < DEPTH);
  localparam logic [SEL_W-1:0] ZSEL = SEL_W'(ZERO_REG);

  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  logic                        r_wr_ignored;
  logic                        w_wr_zero;
  logic                        w_wr_act;
  logic [1:0]                  w_rd_en;
  logic [1:0][SEL_W-1:0]       w_rd_sel;

  assign w_wr_zero = ZACTIVE && (wr_sel == ZSEL);
  assign w_wr_act  = wr_en && !w_wr_zero;
  assign w_rd_en   = {rd_en_b, rd_en_a};
  assign w_rd_sel  = {rd_sel_b, rd_sel_a};

  // Storage: writes land on the rising edge; the zero register is never written.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)      r_mem         <= '0;
    else if (w_wr_act) r_mem[wr_sel] <= wr_data;
  end

  // Flag a dropped write to the zero register for exactly one cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_wr_ignored <= 1'b0;
    else          r_wr_ignored <= wr_en && w_wr_zero;
  end

  assign wr_ignored = r_wr_ignored;

  // Read ports are identical; index 0 = A, 1 = B.
  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [WIDTH-1:0] w_val;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    // Read mux: storage, optional same-edge forward, zero register overrides all.
    always_comb begin
      w_val = r_mem[w_rd_sel[p]];
`ifdef REGFILE_WRITE_BYPASS_EN
      if (w_wr_act && (w_rd_sel[p] == wr_sel)) w_val = wr_data;
`endif
      if (ZACTIVE && (w_rd_sel[p] == ZSEL)) w_val = '0;
    end

    // Registered result; data holds when no request, valid tracks the request.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_data  <= '0;
        r_valid <= 1'b0;
      end else begin
        r_valid <= w_rd_en[p];
        if (w_rd_en[p]) r_data <= w_val;
      end
    end
  end

  assign rd_data_a  = g_rd[0].r_data;
  assign rd_valid_a = g_rd[0].r_valid;
  assign rd_data_b  = g_rd[1].r_data;
  assign rd_valid_b = g_rd[1].r_valid;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench for regfile_2r1w. A second instance with ZERO_EN=0 shares
// the inputs so zero-register behaviour can be contrasted against it.
module tb_regfile_2r1w;
  localparam int WIDTH = 64;
  localparam int SEL_W = 5;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             wr_en;
  logic [SEL_W-1:0] wr_sel;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en_a, rd_en_b;
  logic [SEL_W-1:0] rd_sel_a, rd_sel_b;
  logic [WIDTH-1:0] rd_data_a, rd_data_b;
  logic             rd_valid_a, rd_valid_b, wr_ignored;
  logic [WIDTH-1:0] nz_rd_data_a, nz_rd_data_b;
  logic             nz_rd_valid_a, nz_rd_valid_b, nz_wr_ignored;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  regfile_2r1w #(.WIDTH(WIDTH), .SEL_W(SEL_W), .ZERO_REG(31), .ZERO_EN(1)) u_dut (
    .clock(clock), .reset_n(reset_n),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd_en_a(rd_en_a), .rd_sel_a(rd_sel_a), .rd_data_a(rd_data_a), .rd_valid_a(rd_valid_a),
    .rd_en_b(rd_en_b), .rd_sel_b(rd_sel_b), .rd_data_b(rd_data_b), .rd_valid_b(rd_valid_b),
    .wr_ignored(wr_ignored)
  );

  regfile_2r1w #(.WIDTH(WIDTH), .SEL_W(SEL_W), .ZERO_REG(31), .ZERO_EN(0)) u_dut_nz (
    .clock(clock), .reset_n(reset_n),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd_en_a(rd_en_a), .rd_sel_a(rd_sel_a), .rd_data_a(nz_rd_data_a), .rd_valid_a(nz_rd_valid_a),
    .rd_en_b(rd_en_b), .rd_sel_b(rd_sel_b), .rd_data_b(nz_rd_data_b), .rd_valid_b(nz_rd_valid_b),
    .wr_ignored(nz_wr_ignored)
  );

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; wr_en = 1'b0; wr_sel = '0; wr_data = '0;
    rd_en_a = 1'b0; rd_sel_a = '0; rd_en_b = 1'b0; rd_sel_b = '0;
    repeat (2) step();
    checks++;
    if (rd_data_a !== '0 || rd_valid_a !== 1'b0 || rd_data_b !== '0 ||
        rd_valid_b !== 1'b0 || wr_ignored !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got a=%h va=%b b=%h vb=%b wi=%b required all 0",
               rd_data_a, rd_valid_a, rd_data_b, rd_valid_b, wr_ignored);
    end
    reset_n = 1'b1;
    step();
    wr_en = 1'b1; wr_sel = 5'd3; wr_data = 64'h0123_4567_89AB_CDEF;
    step();
    wr_en = 1'b0; rd_en_a = 1'b1; rd_sel_a = 5'd3;
    step();
    checks++;
    if (rd_data_a !== 64'h0123_4567_89AB_CDEF || rd_valid_a !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_read: got %h v=%b required 0123456789abcdef v=1", rd_data_a, rd_valid_a);
    end
    // rd_en_a is still high: a read is pending when reset hits mid-cycle
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (rd_data_a !== '0 || rd_valid_a !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got %h v=%b required 0 v=0", rd_data_a, rd_valid_a);
    end
    rd_en_a = 1'b0;
    step();
    #2 reset_n = 1'b1;
    step();
    checks++;
    if (rd_valid_a !== 1'b0) begin
      errors++;
      $display("FAIL dropped_read_valid: got %b required 0", rd_valid_a);
    end
    for (int i = 0; i < 31; i++) begin
      rd_en_a = 1'b1; rd_sel_a = 5'(i);
      step();
      checks++;
      if (rd_data_a !== '0 || rd_valid_a !== 1'b1) begin
        errors++;
        $display("FAIL reset_clear reg%0d: got %h v=%b required 0 v=1", i, rd_data_a, rd_valid_a);
      end
    end
    rd_en_a = 1'b0;
    step();
  endtask

  task automatic test_write_read();
    wr_en = 1'b1; wr_sel = 5'd5; wr_data = 64'hDEADBEEF_CAFEF00D;
    step();
    wr_en = 1'b0; rd_en_a = 1'b1; rd_sel_a = 5'd5;
    step();
    checks++;
    if (rd_data_a !== 64'hDEADBEEF_CAFEF00D || rd_valid_a !== 1'b1) begin
      errors++;
      $display("FAIL write_read: got %h v=%b required deadbeefcafef00d v=1", rd_data_a, rd_valid_a);
    end
    rd_en_a = 1'b0;
    step();
    checks++;
    if (rd_valid_a !== 1'b0 || rd_data_a !== 64'hDEADBEEF_CAFEF00D) begin
      errors++;
      $display("FAIL valid_pulse: got v=%b data=%h required v=0 data=deadbeefcafef00d", rd_valid_a, rd_data_a);
    end
  endtask

  task automatic test_zero_reg();
    wr_en = 1'b1; wr_sel = 5'd31; wr_data = 64'h1234;
    step();
    checks++;
    if (wr_ignored !== 1'b1 || nz_wr_ignored !== 1'b0) begin
      errors++;
      $display("FAIL wr_ignored_pulse: got %b nz=%b required 1 nz=0", wr_ignored, nz_wr_ignored);
    end
    wr_en = 1'b0; rd_en_b = 1'b1; rd_sel_b = 5'd31;
    step();
    checks++;
    if (wr_ignored !== 1'b0 || nz_wr_ignored !== 1'b0) begin
      errors++;
      $display("FAIL wr_ignored_one_cycle: got %b nz=%b required 0 nz=0", wr_ignored, nz_wr_ignored);
    end
    checks++;
    if (rd_data_b !== '0 || rd_valid_b !== 1'b1) begin
      errors++;
      $display("FAIL zero_read: got %h v=%b required 0 v=1", rd_data_b, rd_valid_b);
    end
    checks++;
    if (nz_rd_data_b !== 64'h1234 || nz_rd_valid_b !== 1'b1) begin
      errors++;
      $display("FAIL no_zero_read: got %h v=%b required 1234 v=1", nz_rd_data_b, nz_rd_valid_b);
    end
    rd_en_b = 1'b0;
    step();
  endtask

  task automatic test_hazard();
    logic [WIDTH-1:0] exp;
`ifdef REGFILE_WRITE_BYPASS_EN
    exp = 64'hBB;
`else
    exp = 64'hAA;
`endif
    wr_en = 1'b1; wr_sel = 5'd7; wr_data = 64'hAA;
    step();
    wr_data = 64'hBB; rd_en_a = 1'b1; rd_sel_a = 5'd7;
    step();
    checks++;
    if (rd_data_a !== exp) begin
      errors++;
      $display("FAIL same_edge_hazard: got %h required %h", rd_data_a, exp);
    end
    wr_en = 1'b0;
    step();
    checks++;
    if (rd_data_a !== 64'hBB) begin
      errors++;
      $display("FAIL hazard_write_landed: got %h required bb", rd_data_a);
    end
    // Same-edge write/read of the zero register must still read zero
    wr_en = 1'b1; wr_sel = 5'd31; wr_data = 64'h5555; rd_sel_a = 5'd31;
    step();
    checks++;
    if (rd_data_a !== '0) begin
      errors++;
      $display("FAIL zero_hazard: got %h required 0", rd_data_a);
    end
    wr_en = 1'b0; rd_en_a = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 31; i++) begin
      wr_en = 1'b1; wr_sel = 5'(i); wr_data = 64'(i * 3);
      step();
    end
    wr_en = 1'b0;
    for (int k = 0; k < 31; k++) begin
      rd_en_a = 1'b1; rd_sel_a = 5'(k);
      rd_en_b = 1'b1; rd_sel_b = 5'(30 - k);
      step();
      checks++;
      if (rd_data_a !== 64'(k * 3) || rd_valid_a !== 1'b1 ||
          rd_data_b !== 64'((30 - k) * 3) || rd_valid_b !== 1'b1) begin
        errors++;
        $display("FAIL stream cyc%0d: got a=%h va=%b b=%h vb=%b required a=%h b=%h v=1",
                 k, rd_data_a, rd_valid_a, rd_data_b, rd_valid_b, 64'(k * 3), 64'((30 - k) * 3));
      end
    end
    rd_sel_a = 5'd10; rd_sel_b = 5'd10;
    step();
    checks++;
    if (rd_data_a !== 64'd30 || rd_data_b !== 64'd30) begin
      errors++;
      $display("FAIL same_addr_both_ports: got a=%h b=%h required 1e", rd_data_a, rd_data_b);
    end
    rd_en_a = 1'b0; rd_en_b = 1'b0;
    step();
  endtask

  task automatic test_hold();
    rd_en_a = 1'b1; rd_sel_a = 5'd2;
    step();
    checks++;
    if (rd_data_a !== 64'd6 || rd_valid_a !== 1'b1) begin
      errors++;
      $display("FAIL hold_read: got %h v=%b required 6 v=1", rd_data_a, rd_valid_a);
    end
    rd_en_a = 1'b0; wr_en = 1'b1; wr_sel = 5'd2; wr_data = 64'h99;
    step();
    checks++;
    if (rd_valid_a !== 1'b0 || rd_data_a !== 64'd6) begin
      errors++;
      $display("FAIL hold_data: got %h v=%b required 6 v=0", rd_data_a, rd_valid_a);
    end
    wr_en = 1'b0;
    step();
    checks++;
    if (rd_data_a !== 64'd6) begin
      errors++;
      $display("FAIL hold_data_late: got %h required 6", rd_data_a);
    end
    rd_en_a = 1'b1;
    step();
    checks++;
    if (rd_data_a !== 64'h99) begin
      errors++;
      $display("FAIL hold_reread: got %h required 99", rd_data_a);
    end
    rd_en_a = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_reg();
    test_hazard();
    test_back_to_back();
    test_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
